// File: rtl/zero_extend.sv
// Immediate-extension unit: widens an IN_W-bit immediate to an OUT_W-bit operand
// (zero, sign or upper placement), registered with a one-bit valid pipeline.
module zero_extend #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IN_W-1:0]  INPUT,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic [OUT_W-1:0] OUTPUT,
  output logic             OUT_VALID
);

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_RSVD  = 2'b11
  } ext_mode_e;

  localparam int unsigned PAD_W = OUT_W - IN_W;

  if (OUT_W <= IN_W) begin : g_width_check
    $error("zero_extend: OUT_W must be greater than IN_W");
  end

  logic [OUT_W-1:0] result;

  // Reserved code falls through to zero extension.
  always_comb begin
    result = '0;
    case (ext_mode_e'(MODE))
      EXT_SIGN:  result = {{PAD_W{INPUT[IN_W-1]}}, INPUT};
      EXT_UPPER: result[OUT_W-1 -: IN_W] = INPUT;
      default:   result = {{PAD_W{1'b0}}, INPUT};
    endcase
  end

  // OUTPUT holds across invalid cycles; only OUT_VALID drops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUTPUT    <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= IN_VALID;
      if (IN_VALID) begin
        OUTPUT <= result;
      end
    end
  end

endmodule

// File: tb/tb_zero_extend.sv
// Scoreboard bench for zero_extend: directed edge cases, async reset, valid gating
// and randomized stimulus against an independent reference model.
module tb_zero_extend;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  INPUT;
  logic [1:0]  MODE;
  logic        IN_VALID;
  logic [15:0] OUTPUT;
  logic        OUT_VALID;

  int unsigned passed = 0;
  int unsigned total  = 0;

  typedef struct {
    logic [15:0] out;
    logic        vld;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_out = '0;

  zero_extend #(.IN_W(8), .OUT_W(16)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .INPUT(INPUT),
    .MODE(MODE),
    .IN_VALID(IN_VALID),
    .OUTPUT(OUTPUT),
    .OUT_VALID(OUT_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp)
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    else
      passed++;
  endtask

  function automatic logic [15:0] ref_ext(input logic [7:0] in, input logic [1:0] mode);
    case (mode)
      2'd1:    return 16'($signed(in));
      2'd2:    return {in, 8'h00};
      default: return {8'h00, in};
    endcase
  endfunction

  // Drive one cycle at negedge, push expectation, verify no change before the edge,
  // then pop and compare after the capturing edge.
  task automatic step(input logic [7:0] in, input logic [1:0] mode, input logic vld,
                      input logic [15:0] exp_out, input string tag);
    exp_t e;
    @(negedge CLK);
    INPUT    = in;
    MODE     = mode;
    IN_VALID = vld;
    sb.push_back('{out: exp_out, vld: vld, tag: tag});
    #1;
    check({tag, "_pre"}, OUTPUT, last_out);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check({e.tag, "_out"}, OUTPUT, e.out);
    check({e.tag, "_vld"}, 16'(OUT_VALID), 16'(e.vld));
    last_out = exp_out;
  endtask

  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check({tag, "_out"}, OUTPUT, 16'h0000);
    check({tag, "_vld"}, 16'(OUT_VALID), 16'h0000);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST_N    = 1'b1;
    last_out = '0;
  endtask

  initial begin
    logic [7:0]  r_in;
    logic [1:0]  r_mode;
    logic        r_vld;
    logic [15:0] r_exp;

    RST_N    = 1'b0;
    INPUT    = 8'hAA;
    MODE     = 2'b00;
    IN_VALID = 1'b1;

    // Held in reset while valid data is offered.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("rst_hold_out", OUTPUT, 16'h0000);
      check("rst_hold_vld", 16'(OUT_VALID), 16'h0000);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    RST_N    = 1'b1;

    step(8'h00, 2'b00, 1'b1, 16'h0000, "zx_00");
    step(8'hAA, 2'b00, 1'b1, 16'h00AA, "zx_aa");
    step(8'hFF, 2'b00, 1'b1, 16'h00FF, "zx_ff");
    step(8'h47, 2'b00, 1'b1, 16'h0047, "zx_47");

    step(8'h7F, 2'b01, 1'b1, 16'h007F, "sx_7f");
    step(8'h80, 2'b01, 1'b1, 16'hFF80, "sx_80");
    step(8'hAA, 2'b01, 1'b1, 16'hFFAA, "sx_aa");
    step(8'h47, 2'b01, 1'b1, 16'h0047, "sx_47");
    step(8'hFF, 2'b01, 1'b1, 16'hFFFF, "sx_ff");
    step(8'h00, 2'b01, 1'b1, 16'h0000, "sx_00");

    step(8'hAA, 2'b10, 1'b1, 16'hAA00, "up_aa");
    step(8'hFF, 2'b10, 1'b1, 16'hFF00, "up_ff");
    step(8'h00, 2'b10, 1'b1, 16'h0000, "up_00");
    step(8'hAA, 2'b11, 1'b1, 16'h00AA, "rs_aa");

    step(8'hAA, 2'b00, 1'b1, 16'h00AA, "gate_cap");
    for (int i = 0; i < 3; i++)
      step(8'hFF, 2'b01, 1'b0, 16'h00AA, "gate_idle");
    step(8'h47, 2'b00, 1'b1, 16'h0047, "gate_next");

    // Mid-stream asynchronous reset with a nonzero result in the register.
    step(8'hC3, 2'b10, 1'b1, 16'hC300, "pre_rst");
    async_reset("rst_async");
    step(8'h12, 2'b00, 1'b0, 16'h0000, "post_rst");

    for (int i = 0; i < 200; i++) begin
      r_in   = 8'($urandom);
      r_mode = 2'($urandom_range(0, 3));
      r_vld  = ($urandom_range(0, 3) != 0);
      r_exp  = r_vld ? ref_ext(r_in, r_mode) : last_out;
      step(r_in, r_mode, r_vld, r_exp, "rand");
      if ($urandom_range(0, 24) == 0)
        async_reset("rand_rst");
    end

    if (sb.size() != 0)
      check("sb_empty", 16'(sb.size()), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
